serial_alu: RTL
===============

SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on accepted start.
REQ-006 b  input  WIDTH  operand B; captured on accepted start.
REQ-007 c  input  1  carry-in for ADD/SUB; captured on accepted start.
REQ-008 aluctr  input  2  opcode; captured on accepted start.
REQ-009 busy  output  1  high in RUN and DONE states.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 d  output  WIDTH  result; held from done until the next accepted start.
REQ-012 e  output  1  carry-out (ADD/SUB), 0 for logic ops; held like d.
REQ-013 z  output  1  zero flag, high when d == 0; held like d.

Function
REQ-014 Opcodes: 00 AND (a&b), 01 OR (a|b), 10 ADD (a+b+c), 11 SUB (a+~b+c; c=1 gives a-b).
REQ-015 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after bit WIDTH-1 is processed; DONE->IDLE unconditionally.
REQ-016 Accepted start latches a, b, c and aluctr into internal registers; input changes after acceptance do not affect the result.
REQ-017 RUN processes one bit per cycle, LSB first, through a single 1-bit slice; the slice's carry-out is registered and feeds the next bit's carry-in.
REQ-018 Bit counter counts 0..WIDTH-1, width $clog2(WIDTH); no wrap beyond WIDTH-1.
REQ-019 Latency: done is high in the cycle after WIDTH+1 rising edges following the edge that samples start; with WIDTH=8, start sampled at edge 0 gives done high after edge 9.
REQ-020 d, e, z update only at the RUN->DONE transition; they stay stable during RUN.
REQ-021 e = final registered carry for opcodes 10/11; e = 0 for opcodes 00/01.
REQ-022 start while busy is ignored, with no queueing; start in the DONE cycle is ignored.
REQ-023 Minimum start-to-start spacing is WIDTH+2 cycles.
REQ-024 ADD/SUB are modulo 2^WIDTH; overflow is reported only via e.

Reset
REQ-025 rst forces IDLE and clears counter, operand registers, carry register, d, e, busy and done to 0; z resets to 1, consistent with d == 0.
REQ-026 rst has priority over start, including when both are asserted in the same cycle.
REQ-027 rst during RUN or DONE aborts the operation; no done pulse is emitted for it.

Structure
REQ-028 Shared package alu_pkg holds opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB) and FSM state encodings.
REQ-029 One combinational sub-module, alu_bit_slice (inputs a, b, c, aluctr; outputs d, e), is instantiated once; the serial datapath is sequenced around it.
REQ-030 Result bits are assembled in a WIDTH-bit shift register; operands shift right each RUN cycle.

Verification
REQ-031 WIDTH=8, ADD a=0x7F, b=0x01, c=0 -> done after 9 edges, d=0x80, e=0, z=0.
REQ-032 WIDTH=8, SUB a=0x05, b=0x05, c=1 -> d=0x00, e=1, z=1; then SUB a=0x03, b=0x05, c=1 -> d=0xFE, e=0.
REQ-033 WIDTH=8, AND a=0xF0, b=0x3C -> d=0x30, e=0; then OR of the same operands -> d=0xFC, e=0.
REQ-034 WIDTH=8, ADD a=0xFF, b=0x01, c=0; start re-pulsed and a changed mid-RUN -> single done, d=0x00, e=1, z=1.
REQ-035 rst asserted 3 cycles into RUN -> next cycle busy=0, done=0, d=0, z=1; a following start completes normally.
REQ-036 WIDTH=4, ADD a=0xF, b=0xF, c=1 -> done after 5 edges, d=0xF, e=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and helpers for the serial ALU
package alu_pkg;

    // Opcodes carried on aluctr
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Sequencer states; RUN and DONE together make up the busy window
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Arithmetic opcodes (ADD/SUB) are the ones with the upper opcode bit set
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational one-bit ALU slice shared by every bit position
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [1:0] aluctr,
    output logic       d,
    output logic       e
);

    logic b_eff;

    // SUB is ADD with B inverted; carry-out is forced low for the logic opcodes
    always_comb begin
        b_eff = (aluctr == OP_SUB) ? ~b : b;
        d     = 1'b0;
        e     = 1'b0;
        case (aluctr)
            OP_AND: d = a & b;
            OP_OR:  d = a | b;
            default: begin
                d = a ^ b_eff ^ c;
                e = (a & b_eff) | (a & c) | (b_eff & c);
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// rtl/serial_alu.sv - bit-serial ALU: one slice sequenced LSB first over WIDTH cycles
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic [1:0]       aluctr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             e,
    output logic             z
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    // Operand A register doubles as the result shift register: each RUN cycle
    // the consumed A bit leaves at the LSB and the new result bit enters at the MSB
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opb_q;
    logic             carry_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] d_q;
    logic             e_q;
    logic             z_q;
    logic             busy_q;
    logic             done_q;

    logic             slice_d;
    logic             slice_e;
    logic [WIDTH-1:0] acc_d;

    alu_bit_slice u_slice (
        .a      (acc_q[0]),
        .b      (opb_q[0]),
        .c      (carry_q),
        .aluctr (op_q),
        .d      (slice_d),
        .e      (slice_e)
    );

    // Shift register contents after the current bit has been processed
    assign acc_d = {slice_d, acc_q[WIDTH-1:1]};

    // Sequencer: capture on start, one bit per RUN cycle, publish result on RUN->DONE,
    // and pulse done as DONE hands back to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 2'b00;
            d_q     <= '0;
            e_q     <= 1'b0;
            z_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_q   <= a;
                        opb_q   <= b;
                        carry_q <= c;
                        op_q    <= aluctr;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
                    carry_q <= slice_e;
                    if (cnt_q == LAST) begin
                        d_q     <= acc_d;
                        e_q     <= is_arith(op_q) ? slice_e : 1'b0;
                        z_q     <= (acc_d == '0);
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign e    = e_q;
    assign z    = z_q;

endmodule
